// File: rtl/csv_pkg.sv
// Shared definitions for the CSV record decoder: character codes, parser
// state encoding, byte classification and the per-byte action bundle.
package csv_pkg;

   localparam logic [7:0] NULL_CHAR = 8'h00;
   localparam logic [7:0] LF_CHAR   = 8'h0A;
   localparam logic [7:0] CR_CHAR   = 8'h0D;
   localparam logic [7:0] COMA_CHAR = 8'h2C;
   localparam logic [7:0] ZERO_CHAR = 8'h30;
   localparam logic [7:0] NINE_CHAR = 8'h39;

   typedef enum logic [2:0] {
      LINE_START = 3'd0,
      IN_FIELD   = 3'd1,
      AFTER_SEP  = 3'd2,
      SKIP_LINE  = 3'd3,
      EOF        = 3'd4
   } csv_state_t;

   typedef enum logic [2:0] {
      BC_DIGIT = 3'd0,
      BC_SEP   = 3'd1,
      BC_LF    = 3'd2,
      BC_CR    = 3'd3,
      BC_NUL   = 3'd4,
      BC_OTHER = 3'd5
   } byte_class_t;

   // What the datapath does with the byte accepted this cycle.
   typedef struct packed {
      logic acc_clear;
      logic acc_step;
      logic store;
      logic emit;
      logic err;
   } csv_action_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ZERO_CHAR) && (b <= NINE_CHAR);
   endfunction

   // Control characters win over the separator so a misconfigured
   // separator can never swallow LF or NUL.
   function automatic byte_class_t classify_byte(input logic [7:0] b, input logic [7:0] sep);
      byte_class_t c;
      if (b == NULL_CHAR) begin
         c = BC_NUL;
      end else if (b == LF_CHAR) begin
         c = BC_LF;
      end else if (b == CR_CHAR) begin
         c = BC_CR;
      end else if (b == sep) begin
         c = BC_SEP;
      end else if (is_digit(b)) begin
         c = BC_DIGIT;
      end else begin
         c = BC_OTHER;
      end
      return c;
   endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal digit accumulator: value <= value*10 + digit, with a sticky
// overflow flag once the true value no longer fits in FIELD_BITS.
module decimal_accumulator #(
   parameter int FIELD_BITS = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  step,
   input  logic [3:0]            digit,
   output logic [FIELD_BITS-1:0] value,
   output logic                  overflow
);

   // Four extra bits hold value*10+9 for any FIELD_BITS-wide value.
   localparam int WIDE_BITS = FIELD_BITS + 4;

   logic [WIDE_BITS-1:0]  base_s;
   logic [WIDE_BITS-1:0]  next_s;
   logic                  ovf_base_s;
   logic [FIELD_BITS-1:0] value_r;
   logic                  overflow_r;

   // Pick the starting point (fresh field when clear, else running value) and form the next value.
   always_comb begin
      if (clear) begin
         base_s     = {WIDE_BITS{1'b0}};
         ovf_base_s = 1'b0;
      end else begin
         base_s     = {4'd0, value_r};
         ovf_base_s = overflow_r;
      end
      next_s = (base_s * WIDE_BITS'(4'd10)) + {{FIELD_BITS{1'b0}}, digit};
   end

   // Accumulate one digit per step; clear without step just returns to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_r    <= {FIELD_BITS{1'b0}};
         overflow_r <= 1'b0;
      end else if (step) begin
         value_r    <= next_s[FIELD_BITS-1:0];
         overflow_r <= ovf_base_s | (next_s[WIDE_BITS-1:FIELD_BITS] != 4'd0);
      end else if (clear) begin
         value_r    <= {FIELD_BITS{1'b0}};
         overflow_r <= 1'b0;
      end
   end

   assign value    = value_r;
   assign overflow = overflow_r;

endmodule

// File: rtl/csv_record_decoder.sv
// Line-oriented ASCII parser: turns separator-delimited decimal lines into
// packed records, discards malformed lines and counts them.
module csv_record_decoder
   import csv_pkg::*;
#(
   parameter int         NUM_FIELDS   = 2,
   parameter int         FIELD_BITS   = 20,
   parameter logic [7:0] SEPARATOR    = COMA_CHAR,
   parameter int         ERR_CNT_BITS = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             inbound_valid,
   output logic                             inbound_ready,
   input  logic [7:0]                       inbound_byte,
   output logic                             record_valid,
   input  logic                             record_ready,
   output logic [NUM_FIELDS*FIELD_BITS-1:0] record_fields,
   output logic                             record_overflow,
   output logic                             end_of_file,
   output logic [ERR_CNT_BITS-1:0]          error_count
);

   localparam int IDX_BITS = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam logic [IDX_BITS-1:0]     IDX_LAST = IDX_BITS'(NUM_FIELDS - 1);
   localparam logic [ERR_CNT_BITS-1:0] ERR_MAX  = {ERR_CNT_BITS{1'b1}};

   csv_state_t  state_r;
   csv_state_t  state_next_s;
   byte_class_t class_s;
   csv_action_t act_s;

   logic                                   accept_s;
   logic                                   last_field_s;
   logic                                   line_clear_s;
   logic [IDX_BITS-1:0]                    field_idx_r;
   logic                                   rec_ovf_r;
   logic [NUM_FIELDS-1:0][FIELD_BITS-1:0]  fields_r;
   logic [NUM_FIELDS-1:0][FIELD_BITS-1:0]  rec_data_s;
   logic [FIELD_BITS-1:0]                  acc_value_s;
   logic                                   acc_ovf_s;

   logic                                   record_valid_r;
   logic [NUM_FIELDS*FIELD_BITS-1:0]       record_fields_r;
   logic                                   record_overflow_r;
   logic                                   eof_r;
   logic [ERR_CNT_BITS-1:0]                err_cnt_r;

   // A free output slot, or one being drained this cycle, lets a byte in.
   assign inbound_ready = !record_valid_r || record_ready;
   assign accept_s      = inbound_valid && inbound_ready;
   assign class_s       = classify_byte(inbound_byte, SEPARATOR);
   assign last_field_s  = (field_idx_r == IDX_LAST);
   // Leaving the body of a line (closed, skipped or end of input) drops the partial record.
   assign line_clear_s  = accept_s && (state_next_s != IN_FIELD) && (state_next_s != AFTER_SEP);

   decimal_accumulator #(
      .FIELD_BITS(FIELD_BITS)
   ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (act_s.acc_clear),
      .step    (act_s.acc_step),
      .digit   (inbound_byte[3:0]),
      .value   (acc_value_s),
      .overflow(acc_ovf_s)
   );

   // Parser state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= LINE_START;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode for the accepted byte.
   always_comb begin
      state_next_s = state_r;
      if (accept_s) begin
         case (state_r)
            LINE_START, IN_FIELD, AFTER_SEP: begin
               case (class_s)
                  BC_DIGIT: state_next_s = IN_FIELD;
                  BC_SEP:   state_next_s = (state_r == IN_FIELD && !last_field_s) ? AFTER_SEP : SKIP_LINE;
                  BC_LF:    state_next_s = LINE_START;
                  BC_CR:    state_next_s = state_r;
                  BC_NUL:   state_next_s = EOF;
                  default:  state_next_s = SKIP_LINE;
               endcase
            end
            SKIP_LINE: begin
               if (class_s == BC_LF) begin
                  state_next_s = LINE_START;
               end else if (class_s == BC_NUL) begin
                  state_next_s = EOF;
               end else begin
                  state_next_s = SKIP_LINE;
               end
            end
            EOF:     state_next_s = EOF;
            default: state_next_s = LINE_START;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Datapath actions for the accepted byte: accumulate, store, emit or flag an error.
   always_comb begin
      act_s = '{default: 1'b0};
      if (accept_s) begin
         case (state_r)
            LINE_START, AFTER_SEP: begin
               case (class_s)
                  BC_DIGIT: begin
                     act_s.acc_clear = 1'b1;
                     act_s.acc_step  = 1'b1;
                  end
                  BC_SEP, BC_OTHER: act_s.err = 1'b1;
                  BC_LF, BC_NUL:    act_s.err = (state_r == AFTER_SEP);
                  default:          act_s.err = 1'b0;
               endcase
            end
            IN_FIELD: begin
               case (class_s)
                  BC_DIGIT: act_s.acc_step = 1'b1;
                  BC_SEP: begin
                     if (last_field_s) begin
                        act_s.err = 1'b1;
                     end else begin
                        act_s.store = 1'b1;
                     end
                  end
                  BC_LF: begin
                     if (last_field_s) begin
                        act_s.emit = 1'b1;
                     end else begin
                        act_s.err = 1'b1;
                     end
                  end
                  BC_NUL, BC_OTHER: act_s.err = 1'b1;
                  default:          act_s.err = 1'b0;
               endcase
            end
            SKIP_LINE: act_s.err = (class_s == BC_NUL);
            default:   act_s = '{default: 1'b0};
         endcase
      end else begin
         act_s = '{default: 1'b0};
      end
   end

   // The final field comes straight from the accumulator on the closing LF.
   always_comb begin
      rec_data_s = fields_r;
      rec_data_s[NUM_FIELDS-1] = acc_value_s;
   end

   // Field index, per-record overflow flag and stored fields of the line in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         field_idx_r <= {IDX_BITS{1'b0}};
         rec_ovf_r   <= 1'b0;
         fields_r    <= {(NUM_FIELDS*FIELD_BITS){1'b0}};
      end else begin
         if (line_clear_s) begin
            field_idx_r <= {IDX_BITS{1'b0}};
            rec_ovf_r   <= 1'b0;
         end else if (act_s.store) begin
            field_idx_r <= field_idx_r + IDX_BITS'(1'b1);
            rec_ovf_r   <= rec_ovf_r | acc_ovf_s;
         end
         for (int i = 0; i < NUM_FIELDS; i++) begin
            if (act_s.store && (field_idx_r == IDX_BITS'(i))) begin
               fields_r[i] <= acc_value_s;
            end
         end
      end
   end

   // One-deep output register; a new record may replace one draining in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         record_valid_r    <= 1'b0;
         record_fields_r   <= {(NUM_FIELDS*FIELD_BITS){1'b0}};
         record_overflow_r <= 1'b0;
      end else if (act_s.emit) begin
         record_valid_r    <= 1'b1;
         record_fields_r   <= rec_data_s;
         record_overflow_r <= rec_ovf_r | acc_ovf_s;
      end else if (record_ready) begin
         record_valid_r    <= 1'b0;
      end
   end

   // Sticky end-of-input flag and saturating discarded-line counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eof_r     <= 1'b0;
         err_cnt_r <= {ERR_CNT_BITS{1'b0}};
      end else begin
         if (accept_s && (state_next_s == EOF)) begin
            eof_r <= 1'b1;
         end
         if (act_s.err && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_BITS'(1'b1);
         end
      end
   end

   assign record_valid    = record_valid_r;
   assign record_fields   = record_fields_r;
   assign record_overflow = record_overflow_r;
   assign end_of_file     = eof_r;
   assign error_count     = err_cnt_r;

endmodule

// File: tb/tb_csv_record_decoder.sv
// Directed bench for csv_record_decoder: three instances cover two fields,
// three fields and an 8-bit field width.
module tb_csv_record_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   nvec = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   // Cycle counter used to measure throughput.
   always @(posedge clk) cyc <= cyc + 1;

   logic        iv2 = 1'b0, rr2 = 1'b1, ir2, rv2, ro2, eof2;
   logic [7:0]  ib2 = 8'h00;
   logic [39:0] rf2;
   logic [15:0] ec2;

   logic        iv3 = 1'b0, rr3 = 1'b1, ir3, rv3, ro3, eof3;
   logic [7:0]  ib3 = 8'h00;
   logic [59:0] rf3;
   logic [15:0] ec3;

   logic        iv8 = 1'b0, rr8 = 1'b1, ir8, rv8, ro8, eof8;
   logic [7:0]  ib8 = 8'h00;
   logic [15:0] rf8;
   logic [15:0] ec8;

   logic [59:0] q2[$];
   logic [59:0] q3[$];

   csv_record_decoder #(.NUM_FIELDS(2), .FIELD_BITS(20), .SEPARATOR(8'h2C), .ERR_CNT_BITS(16)) u_d2 (
      .clk(clk), .rst_n(rst_n), .inbound_valid(iv2), .inbound_ready(ir2), .inbound_byte(ib2),
      .record_valid(rv2), .record_ready(rr2), .record_fields(rf2), .record_overflow(ro2),
      .end_of_file(eof2), .error_count(ec2));

   csv_record_decoder #(.NUM_FIELDS(3), .FIELD_BITS(20), .SEPARATOR(8'h2C), .ERR_CNT_BITS(16)) u_d3 (
      .clk(clk), .rst_n(rst_n), .inbound_valid(iv3), .inbound_ready(ir3), .inbound_byte(ib3),
      .record_valid(rv3), .record_ready(rr3), .record_fields(rf3), .record_overflow(ro3),
      .end_of_file(eof3), .error_count(ec3));

   csv_record_decoder #(.NUM_FIELDS(2), .FIELD_BITS(8), .SEPARATOR(8'h2C), .ERR_CNT_BITS(16)) u_d8 (
      .clk(clk), .rst_n(rst_n), .inbound_valid(iv8), .inbound_ready(ir8), .inbound_byte(ib8),
      .record_valid(rv8), .record_ready(rr8), .record_fields(rf8), .record_overflow(ro8),
      .end_of_file(eof8), .error_count(ec8));

   // Record every output handshake of the multi-record instances.
   always @(negedge clk) begin
      if (rv2 && rr2) q2.push_back({20'd0, rf2});
      if (rv3 && rr3) q3.push_back(rf3);
   end

   task automatic drive(input int sel, input logic v, input logic [7:0] b);
      case (sel)
         2:       begin iv2 = v; ib2 = b; end
         3:       begin iv3 = v; ib3 = b; end
         default: begin iv8 = v; ib8 = b; end
      endcase
   endtask

   function automatic logic rdy(input int sel);
      case (sel)
         2:       return ir2;
         3:       return ir3;
         default: return ir8;
      endcase
   endfunction

   // Offer one byte starting just after a rising edge; returns just after the accepting edge.
   task automatic send(input int sel, input logic [7:0] b);
      int n;
      n = 0;
      drive(sel, 1'b1, b);
      @(negedge clk);
      while (!rdy(sel) && n < 100) begin
         @(negedge clk);
         n++;
      end
      nvec++;
      if (n >= 100) begin
         nfail++;
         $display("FAIL send_timeout sel=%0d byte=%h got ready=0 want ready=1", sel, b);
      end
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 8'h00);
   endtask

   task automatic send_str(input int sel, input string s);
      for (int i = 0; i < s.len(); i++) send(sel, s[i]);
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      q2.delete();
      q3.delete();
   endtask

   task automatic test_reset();
      nvec++; if (rv2 !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", rv2); end
      nvec++; if (rf2 !== 40'd0) begin nfail++; $display("FAIL reset_fields got %h want 0", rf2); end
      nvec++; if (ro2 !== 1'b0) begin nfail++; $display("FAIL reset_overflow got %b want 0", ro2); end
      nvec++; if (eof2 !== 1'b0) begin nfail++; $display("FAIL reset_eof got %b want 0", eof2); end
      nvec++; if (ec2 !== 16'd0) begin nfail++; $display("FAIL reset_errcnt got %0d want 0", ec2); end
      nvec++; if (ir2 !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b want 1", ir2); end
      nvec++; if (rf8 !== 16'd0 || ec8 !== 16'd0) begin nfail++; $display("FAIL reset_d8 got fields=%h err=%0d want 0/0", rf8, ec8); end
   endtask

   task automatic test_basic();
      int t0;
      t0 = cyc;
      send_str(2, "7,1\n");
      nvec++; if (rv2 !== 1'b1 || rf2 !== {20'd1, 20'd7}) begin nfail++; $display("FAIL basic_rec0 got v=%b f=%h want v=1 f=%h", rv2, rf2, {20'd1, 20'd7}); end
      nvec++; if (cyc - t0 !== 4) begin nfail++; $display("FAIL basic_throughput got %0d cycles want 4", cyc - t0); end
      send_str(2, "11,7\n");
      nvec++; if (rv2 !== 1'b1 || rf2 !== {20'd7, 20'd11}) begin nfail++; $display("FAIL basic_rec1 got v=%b f=%h want v=1 f=%h", rv2, rf2, {20'd7, 20'd11}); end
      nvec++; if (eof2 !== 1'b0) begin nfail++; $display("FAIL basic_eof_early got %b want 0", eof2); end
      send(2, 8'h00);
      nvec++; if (eof2 !== 1'b1) begin nfail++; $display("FAIL basic_eof got %b want 1", eof2); end
      nvec++; if (ec2 !== 16'd0) begin nfail++; $display("FAIL basic_errcnt got %0d want 0", ec2); end
      settle();
      nvec++;
      if (q2.size() !== 2) begin
         nfail++; $display("FAIL basic_count got %0d want 2", q2.size());
      end else begin
         nvec++; if (q2[0] !== {20'd0, 20'd1, 20'd7}) begin nfail++; $display("FAIL basic_q0 got %h want (7,1)", q2[0]); end
         nvec++; if (q2[1] !== {20'd0, 20'd7, 20'd11}) begin nfail++; $display("FAIL basic_q1 got %h want (11,7)", q2[1]); end
      end
   endtask

   task automatic test_three_fields();
      send_str(3, "1,2,3\r\n\n4,5,6\n");
      nvec++; if (rv3 !== 1'b1 || rf3 !== {20'd6, 20'd5, 20'd4}) begin nfail++; $display("FAIL three_last got v=%b f=%h want (4,5,6)", rv3, rf3); end
      nvec++; if (ec3 !== 16'd0) begin nfail++; $display("FAIL three_errcnt got %0d want 0", ec3); end
      settle();
      nvec++;
      if (q3.size() !== 2) begin
         nfail++; $display("FAIL three_count got %0d want 2", q3.size());
      end else begin
         nvec++; if (q3[0] !== {20'd3, 20'd2, 20'd1}) begin nfail++; $display("FAIL three_q0 got %h want (1,2,3)", q3[0]); end
      end
   endtask

   task automatic test_overflow();
      send_str(8, "300,5\n");
      nvec++; if (rv8 !== 1'b1 || rf8 !== {8'd5, 8'd44}) begin nfail++; $display("FAIL ovf_fields got v=%b f=%h want %h", rv8, rf8, {8'd5, 8'd44}); end
      nvec++; if (ro8 !== 1'b1) begin nfail++; $display("FAIL ovf_flag got %b want 1", ro8); end
      send_str(8, "255,0\n");
      nvec++; if (rf8 !== {8'd0, 8'd255} || ro8 !== 1'b0) begin nfail++; $display("FAIL ovf_edge255 got f=%h o=%b want %h o=0", rf8, ro8, {8'd0, 8'd255}); end
      send_str(8, "1,256\n");
      nvec++; if (rf8 !== {8'd0, 8'd1} || ro8 !== 1'b1) begin nfail++; $display("FAIL ovf_last256 got f=%h o=%b want %h o=1", rf8, ro8, {8'd0, 8'd1}); end
      nvec++; if (ec8 !== 16'd0) begin nfail++; $display("FAIL ovf_errcnt got %0d want 0", ec8); end
   endtask

   task automatic test_malformed();
      send_str(2, "1,,2\n1,2,3\na,1\n9,9\n");
      nvec++; if (rv2 !== 1'b1 || rf2 !== {20'd9, 20'd9}) begin nfail++; $display("FAIL bad_rec got v=%b f=%h want (9,9)", rv2, rf2); end
      nvec++; if (ec2 !== 16'd3) begin nfail++; $display("FAIL bad_errcnt3 got %0d want 3", ec2); end
      send_str(2, "5\n2,3\n");
      nvec++; if (ec2 !== 16'd4) begin nfail++; $display("FAIL bad_errcnt4 got %0d want 4", ec2); end
      nvec++; if (rf2 !== {20'd3, 20'd2}) begin nfail++; $display("FAIL bad_after_short got %h want (2,3)", rf2); end
      settle();
      nvec++;
      if (q2.size() !== 2) begin
         nfail++; $display("FAIL bad_count got %0d want 2", q2.size());
      end else begin
         nvec++; if (q2[0] !== {20'd0, 20'd9, 20'd9}) begin nfail++; $display("FAIL bad_q0 got %h want (9,9)", q2[0]); end
      end
   endtask

   task automatic test_stall();
      rr2 = 1'b0;
      send_str(2, "1,2\n");
      fork
         send_str(2, "3,4\n");
         begin
            repeat (10) begin
               @(negedge clk);
               nvec++;
               if (ir2 !== 1'b0 || rv2 !== 1'b1 || rf2 !== {20'd2, 20'd1}) begin
                  nfail++; $display("FAIL stall_hold got ready=%b v=%b f=%h want 0/1/(1,2)", ir2, rv2, rf2);
               end
            end
            @(posedge clk);
            #1;
            rr2 = 1'b1;
         end
      join
      settle();
      nvec++;
      if (q2.size() !== 2) begin
         nfail++; $display("FAIL stall_count got %0d want 2", q2.size());
      end else begin
         nvec++; if (q2[0] !== {20'd0, 20'd2, 20'd1}) begin nfail++; $display("FAIL stall_q0 got %h want (1,2)", q2[0]); end
         nvec++; if (q2[1] !== {20'd0, 20'd4, 20'd3}) begin nfail++; $display("FAIL stall_q1 got %h want (3,4)", q2[1]); end
      end
   endtask

   task automatic test_eof_partial();
      send_str(2, "5,6");
      send(2, 8'h00);
      nvec++; if (eof2 !== 1'b1) begin nfail++; $display("FAIL eofp_flag got %b want 1", eof2); end
      nvec++; if (ec2 !== 16'd1) begin nfail++; $display("FAIL eofp_errcnt got %0d want 1", ec2); end
      nvec++; if (rv2 !== 1'b0) begin nfail++; $display("FAIL eofp_valid got %b want 0", rv2); end
      send_str(2, "1,2\nx\n");
      nvec++; if (ec2 !== 16'd1 || eof2 !== 1'b1) begin nfail++; $display("FAIL eofp_ignore got err=%0d eof=%b want 1/1", ec2, eof2); end
      settle();
      nvec++; if (q2.size() !== 0) begin nfail++; $display("FAIL eofp_count got %0d want 0", q2.size()); end
   endtask

   task automatic test_reset_mid();
      rr2 = 1'b0;
      send_str(2, "x\n4,5\n");
      nvec++; if (ec2 !== 16'd1 || rv2 !== 1'b1) begin nfail++; $display("FAIL rmid_pre got err=%0d v=%b want 1/1", ec2, rv2); end
      #2;
      rst_n = 1'b0;
      #1;
      nvec++; if (rv2 !== 1'b0 || rf2 !== 40'd0 || ro2 !== 1'b0) begin nfail++; $display("FAIL rmid_rec got v=%b f=%h o=%b want 0/0/0", rv2, rf2, ro2); end
      nvec++; if (ec2 !== 16'd0 || eof2 !== 1'b0 || ir2 !== 1'b1) begin nfail++; $display("FAIL rmid_status got err=%0d eof=%b rdy=%b want 0/0/1", ec2, eof2, ir2); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rr2 = 1'b1;
      @(posedge clk);
      #1;
      send_str(2, "1,");
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_str(2, "3,4\n");
      nvec++; if (rv2 !== 1'b1 || rf2 !== {20'd4, 20'd3}) begin nfail++; $display("FAIL rmid_clean got v=%b f=%h want (3,4)", rv2, rf2); end
      nvec++; if (ec2 !== 16'd0) begin nfail++; $display("FAIL rmid_errcnt got %0d want 0", ec2); end
   endtask

   // Bound on total run time in case a handshake never completes.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_basic();
      do_reset();
      test_three_fields();
      test_overflow();
      do_reset();
      test_malformed();
      do_reset();
      test_stall();
      do_reset();
      test_eof_partial();
      do_reset();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/csv_record_decoder.md
# csv_record_decoder

Parametrised ASCII record parser: converts an inbound byte stream of lines of `NUM_FIELDS` separator-delimited unsigned decimal integers into one packed record per line. Sits directly behind the byte source (UART/ROM loader) and feeds puzzle solvers. It adds the following:
- Configurable field count, field width and separator.
- Ready/valid backpressure on both sides.
- Malformed-line and overflow detection, with a saturating error counter.

## Interface
Parameters:
- `NUM_FIELDS`, 2: integers per line, ≥1.
- `FIELD_BITS`, 20: width of each decoded integer.
- `SEPARATOR`, 8'h2C: field separator byte (`,`).
- `ERR_CNT_BITS`, 16: width of the error counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `inbound_valid`  in  1: byte present.
- `inbound_ready`  out  1: byte accepted when valid and ready are both high.
- `inbound_byte`  in  8: ASCII byte.
- `record_valid`  out  1: record available; held until accepted.
- `record_ready`  in  1: downstream accepts the record.
- `record_fields`  out  NUM_FIELDS*FIELD_BITS: field 0 in the LSBs.
- `record_overflow`  out  1: at least one field of this record overflowed `FIELD_BITS`; qualified by `record_valid`.
- `end_of_file`  out  1: sticky after NUL is accepted.
- `error_count`  out  ERR_CNT_BITS: saturating count of discarded lines.

## Operation
- Byte classes:
  - Digit: 0x30–0x39.
  - `SEPARATOR`.
  - LF: 0x0A.
  - CR: 0x0D, always ignored.
  - NUL: 0x00.
  - Other: any remaining byte.
- State machine `LINE_START`, `IN_FIELD`, `AFTER_SEP`, `SKIP_LINE`, `EOF`; reset state is `LINE_START`. Internal state is `field_idx` (0..NUM_FIELDS-1), accumulator `acc` and a per-record overflow flag.
- Digit, in `LINE_START`, `AFTER_SEP` or `IN_FIELD`:
  - Sets `acc` = `acc`*10 + digit; `acc` is zeroed on entry to a field.
  - Arithmetic is computed at FIELD_BITS+4 bits. If the result exceeds 2^FIELD_BITS−1, set the overflow flag; the stored value is the low FIELD_BITS bits.
  - Next state `IN_FIELD`.
- `SEPARATOR` in `IN_FIELD` with `field_idx` < NUM_FIELDS−1: store `acc` into field `field_idx`, increment `field_idx`, go to `AFTER_SEP`.
- LF in `IN_FIELD` with `field_idx` == NUM_FIELDS−1:
  - Store the last field, load the output register, assert `record_valid`.
  - Clear `field_idx` and the overflow flag; go to `LINE_START`.
- LF in `LINE_START` (empty line): ignored, no error.
- Malformed line, any one of:
  - `SEPARATOR` in the wrong place: in `LINE_START`, in `AFTER_SEP`, or when `field_idx` is already NUM_FIELDS−1.
  - LF with too few fields.
  - LF in `AFTER_SEP`.
  - Any Other byte.
- On a malformed line:
  - `error_count` +1, saturating at all-ones.
  - Partial record discarded, no output.
  - LF closes the line immediately (go to `LINE_START`). Any other offending byte goes to `SKIP_LINE`, which discards bytes until LF, then returns to `LINE_START`.
- NUL in any state:
  - Go to `EOF`; `end_of_file` is set.
  - If the state was `IN_FIELD`, `AFTER_SEP` or `SKIP_LINE`, `error_count` +1; a trailing partial record is never emitted.
- In `EOF`, all further bytes are accepted and ignored. Only `rst_n` leaves `EOF`.
- Output register holds one record.
  - `inbound_ready` = !`record_valid` || `record_ready` (combinational path from `record_ready` to `inbound_ready`).
  - `record_valid` clears on handshake, unless a new record loads in the same cycle, in which case it stays high with the new data.

## Timing
- Reset values, all outputs: `record_valid`=0, `record_fields`=0, `record_overflow`=0, `end_of_file`=0, `error_count`=0.
- `inbound_ready` is 1 out of reset, since `record_valid`=0.
- Latency: LF accepted at edge N gives `record_valid`=1 after edge N, i.e. one cycle.
- `error_count` and `end_of_file` update on the edge that accepts the offending byte or the NUL.
- Throughput: one byte per cycle while downstream keeps `record_ready` high.
- A stalled record holds `record_fields` and `record_overflow` stable.
- `rst_n` asserted mid-line or mid-stall clears everything asynchronously. A pending record is lost.

## Structure
- Package `csv_pkg`:
  - Character constants: `NULL_CHAR`, `LF_CHAR`, `CR_CHAR`, `COMA_CHAR`, `ZERO_CHAR`, `NINE_CHAR`.
  - `is_digit()` function.
  - State enum `csv_state_t`.
- Sub-module `decimal_accumulator`, with parameter FIELD_BITS:
  - Inputs: clear, step, digit.
  - Outputs: value, sticky overflow.
  - Reusable by other parsers.
- The top level holds the FSM, field storage, output register and error counter.

## Test plan
- NUM_FIELDS=2, stream "7,1\n11,7\n" then NUL, with `record_ready`=1:
  - Two records, (7,1) then (11,7), each one cycle after its LF.
  - `end_of_file`=1 after the NUL; `error_count`=0.
- NUM_FIELDS=3, "1,2,3\r\n\n4,5,6\n":
  - Records (1,2,3) and (4,5,6); CR and the empty line ignored; no errors.
- FIELD_BITS=8, "300,5\n":
  - Record field0=44 (300 mod 256), field1=5; `record_overflow`=1.
- "1,,2\n", "1,2,3\n", "a,1\n", "9,9\n" with NUM_FIELDS=2:
  - Only (9,9) is emitted; `error_count`=3.
- Hold `record_ready`=0 after the first record of "1,2\n3,4\n":
  - `inbound_ready`=0 and `record_fields` stable for 10 cycles.
  - After release, (1,2) then (3,4), no byte lost.
- "5,6" then NUL:
  - No record, `error_count`=1, `end_of_file`=1.
  - Later bytes are accepted and ignored.
- Also: assert `rst_n` mid-line:
  - All outputs return to reset values immediately.
  - A clean line that follows decodes correctly.
